bfm_ahbl2apb: RTL and testbench



---
 rtl/bfm_ahbl2apb_pkg.sv | 38 +++
 rtl/bfm_ahbl2apb_wdog.sv | 50 +++++
 rtl/bfm_ahbl2apb.sv | 189 ++++++++++++++++++
 tb/tb_bfm_ahbl2apb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bfm_ahbl2apb_pkg.sv
// Shared definitions for the AHB-Lite to APB3 bridge.
// - state_e     : bridge FSM state encoding
// - Htrans*     : AHB HTRANS transfer-type codes
// - Hresp*      : AHB HRESP response codes
// - WdogWidth   : width of the APB access watchdog counter
// - is_active_trans : 1 for NONSEQ/SEQ, the only types that start a transfer
package bfm_ahbl2apb_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLatch  = 3'd1,
    StSetup  = 3'd2,
    StAccess = 3'd3,
    StErr1   = 3'd4,
    StErr2   = 3'd5
  } state_e;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  localparam int unsigned WdogWidth = 16;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HtransNonseq, HtransSeq: active = 1'b1;
      HtransIdle, HtransBusy:  active = 1'b0;
      default:                 active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/bfm_ahbl2apb_wdog.sv
// APB access watchdog.
// Counts consecutive PREADY-low ACCESS cycles and pulses expire_o in the cycle whose
// increment makes the count reach Timeout. Timeout = 0 disables it (counter held at 0,
// expire_o never asserted).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear the count (start of an access)
//   inc_i         : a PREADY-low ACCESS cycle
//   expire_o      : combinational abort pulse
module bfm_ahbl2apb_wdog
  import bfm_ahbl2apb_pkg::*;
#(
  parameter int unsigned Timeout = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [WdogWidth:0] Limit   = (WdogWidth + 1)'(Timeout);
  localparam logic               Enabled = (Timeout != 0);

  logic [WdogWidth-1:0] cnt_q, cnt_d;
  logic [WdogWidth:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (!Enabled || clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !cnt_inc[WdogWidth]) begin
      // Saturate rather than wrap; only matters if nothing completes for 64k cycles.
      cnt_d = cnt_inc[WdogWidth-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = Enabled && inc_i && !clr_i && (cnt_inc == Limit);

endmodule

// File: rtl/bfm_ahbl2apb.sv
// AHB-Lite slave to APB3 master bridge, single clock domain.
// Each accepted NONSEQ/SEQ transfer becomes one APB SETUP/ACCESS transfer. A stuck
// access is aborted by the watchdog after Timeout PREADY-low cycles (0 = never).
// All outputs are registered.
// Ports:
//   hclk_i, hresetn_i           : clock, asynchronous active-low reset
//   hsel_i .. hready_i          : AHB-Lite slave inputs (hsize_i is ignored)
//   hreadyout_o, hresp_o, hrdata_o : AHB-Lite slave outputs
//   psel_o .. pwdata_o          : APB3 master outputs
//   prdata_i, pready_i, pslverr_i : APB3 master inputs
module bfm_ahbl2apb
  import bfm_ahbl2apb_pkg::*;
#(
  parameter int unsigned Timeout = 0
) (
  input  logic        hclk_i,
  input  logic        hresetn_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic        hwrite_i,
  input  logic [1:0]  htrans_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o,
  output logic        psel_o,
  output logic [31:0] paddr_o,
  output logic        pwrite_o,
  output logic        penable_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic        hreadyout_q, hreadyout_d;
  logic        hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        psel_q, psel_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic addr_valid;
  logic wd_clr, wd_inc, wd_expire;

  // All transfers are treated as 32-bit.
  logic unused_hsize;
  assign unused_hsize = ^hsize_i;

  assign addr_valid = hsel_i && hready_i && is_active_trans(htrans_i);

  bfm_ahbl2apb_wdog #(
    .Timeout (Timeout)
  ) u_wdog (
    .clk_i    (hclk_i),
    .rst_ni   (hresetn_i),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;

    unique case (state_q)
      // ERR2 is the second error-response cycle but already samples the next address.
      StIdle, StErr2: begin
        hreadyout_d = 1'b1;
        hresp_d     = HrespOkay;
        if (addr_valid) begin
          addr_d      = haddr_i;
          write_d     = hwrite_i;
          hreadyout_d = 1'b0;
          state_d     = StLatch;
        end
      end

      // HWDATA is valid here (AHB data phase).
      StLatch: begin
        if (write_q) begin
          pwdata_d = hwdata_i;
        end
        paddr_d  = addr_q;
        pwrite_d = write_q;
        psel_d   = 1'b1;
        state_d  = StSetup;
      end

      StSetup: begin
        penable_d = 1'b1;
        wd_clr    = 1'b1;
        state_d   = StAccess;
      end

      StAccess: begin
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) begin
            hrdata_d = prdata_i;
          end
          if (!pslverr_i) begin
            hreadyout_d = 1'b1;
            state_d     = StIdle;
          end else begin
            hresp_d = HrespError;
            state_d = StErr1;
          end
        end else begin
          wd_inc = 1'b1;
          if (wd_expire) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            hresp_d   = HrespError;
            state_d   = StErr1;
          end
        end
      end

      // First error cycle (HREADYOUT low) is already on the bus; raise HREADYOUT.
      StErr1: begin
        hreadyout_d = 1'b1;
        hresp_d     = HrespError;
        state_d     = StErr2;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HrespOkay;
      hrdata_q    <= '0;
      psel_q      <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = hrdata_q;
  assign psel_o      = psel_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign penable_o   = penable_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_bfm_ahbl2apb.sv
// Self-checking bench for bfm_ahbl2apb: directed cases plus randomized transfers.
// The reference model tracks, per transfer, the expected APB fields, the number of
// ACCESS cycles (waits + 1, or Timeout when aborted) and the expected AHB response.
module tb_bfm_ahbl2apb;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the bridge should be presenting when idle.
  logic [31:0] m_hrdata = '0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_paddr  = '0;
  logic        m_pwrite = 1'b0;

  always #5 clk = ~clk;

  bfm_ahbl2apb #(
    .Timeout (Timeout)
  ) dut (
    .hclk_i      (clk),
    .hresetn_i   (hresetn),
    .hsel_i      (hsel),
    .haddr_i     (haddr),
    .hwrite_i    (hwrite),
    .htrans_i    (htrans),
    .hsize_i     (hsize),
    .hwdata_i    (hwdata),
    .hready_i    (hready),
    .hreadyout_o (hreadyout),
    .hresp_o     (hresp),
    .hrdata_o    (hrdata),
    .psel_o      (psel),
    .paddr_o     (paddr),
    .pwrite_o    (pwrite),
    .penable_o   (penable),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hready = 1'b1;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
  endtask

  task automatic check_idle_out(input string tag);
    check_eq({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    check_eq({tag, "_hresp"},     32'(hresp),     32'd0);
    check_eq({tag, "_psel"},      32'(psel),      32'd0);
    check_eq({tag, "_penable"},   32'(penable),   32'd0);
    check_eq({tag, "_hrdata"},    hrdata,         m_hrdata);
    check_eq({tag, "_paddr"},     paddr,          m_paddr);
    check_eq({tag, "_pwrite"},    32'(pwrite),    32'(m_pwrite));
    check_eq({tag, "_pwdata"},    pwdata,         m_pwdata);
  endtask

  // One non-transfer beat; entered just after a rising edge.
  // kind 0: BUSY, 1: HSEL low, 2: IDLE, 3: NONSEQ with HREADY low.
  task automatic filter_beat(input int kind);
    drive_idle_bus();
    case (kind)
      0:       begin hsel = 1'b1; htrans = 2'b01; end
      1:       begin hsel = 1'b0; htrans = 2'b10; end
      2:       begin hsel = 1'b1; htrans = 2'b00; end
      default: begin hsel = 1'b1; htrans = 2'b10; hready = 1'b0; end
    endcase
    @(negedge clk);
    check_idle_out("filter");
    @(posedge clk); #1;
    drive_idle_bus();
  endtask

  // Full transfer; entered just after the rising edge that starts the address phase.
  task automatic xfer(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                      input logic err);
    bit aborted;
    int n_acc;
    bit last;
    aborted = (Timeout != 0) && (waits >= int'(Timeout));
    n_acc   = aborted ? int'(Timeout) : waits + 1;

    // T0: address phase; outputs still show the previous completion.
    hsel = 1'b1; htrans = trans; hready = 1'b1; haddr = addr; hwrite = wr;
    hsize = 3'($urandom); pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    @(negedge clk);
    check_idle_out("t0");

    // T1: data phase; a pending request held with HREADY low must be ignored.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hready = 1'b0; haddr = $urandom; hwrite = 1'($urandom);
    hwdata = wdata;
    @(negedge clk);
    check_eq("t1_hreadyout", 32'(hreadyout), 32'd0);
    check_eq("t1_psel",      32'(psel),      32'd0);

    // T2: APB SETUP.
    @(posedge clk); #1;
    hwdata = $urandom;
    if (wr) m_pwdata = wdata;
    m_paddr  = addr;
    m_pwrite = wr;
    @(negedge clk);
    check_eq("setup_psel",      32'(psel),      32'd1);
    check_eq("setup_penable",   32'(penable),   32'd0);
    check_eq("setup_paddr",     paddr,          m_paddr);
    check_eq("setup_pwrite",    32'(pwrite),    32'(m_pwrite));
    check_eq("setup_pwdata",    pwdata,         m_pwdata);
    check_eq("setup_hreadyout", 32'(hreadyout), 32'd0);

    // ACCESS cycles; PRDATA/PSLVERR are garbage unless PREADY is high.
    for (int k = 0; k < n_acc; k++) begin
      @(posedge clk); #1;
      last    = !aborted && (k == n_acc - 1);
      pready  = last;
      prdata  = last ? rdata : $urandom;
      pslverr = last ? err : 1'($urandom);
      @(negedge clk);
      check_eq("acc_psel",      32'(psel),      32'd1);
      check_eq("acc_penable",   32'(penable),   32'd1);
      check_eq("acc_hreadyout", 32'(hreadyout), 32'd0);
      check_eq("acc_hresp",     32'(hresp),     32'd0);
    end

    @(posedge clk); #1;
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    if (!aborted && !wr) m_hrdata = rdata;
    if (aborted || err) begin
      hsel = 1'b0; htrans = 2'b00; hready = 1'b0;
      @(negedge clk);
      check_eq("err1_hreadyout", 32'(hreadyout), 32'd0);
      check_eq("err1_hresp",     32'(hresp),     32'd1);
      check_eq("err1_psel",      32'(psel),      32'd0);
      check_eq("err1_penable",   32'(penable),   32'd0);
      check_eq("err1_hrdata",    hrdata,         m_hrdata);
      @(posedge clk); #1;
      drive_idle_bus();
      @(negedge clk);
      check_eq("err2_hreadyout", 32'(hreadyout), 32'd1);
      check_eq("err2_hresp",     32'(hresp),     32'd1);
      @(posedge clk); #1;
    end
    // Normal completion returns at the start of T4 so the next address can go there.
    drive_idle_bus();
  endtask

  // Read that is killed by reset in its second ACCESS cycle.
  task automatic reset_mid_access(input logic [31:0] addr);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = addr; hwrite = 1'b0;
    pready = 1'b0;
    @(negedge clk);
    check_idle_out("rst_t0");
    @(posedge clk); #1;
    drive_idle_bus();
    hready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_acc_penable", 32'(penable), 32'd1);
    @(posedge clk); #3;
    hresetn = 1'b0;
    #1;
    m_hrdata = '0; m_pwdata = '0; m_paddr = '0; m_pwrite = 1'b0;
    check_idle_out("rst_async");
    @(negedge clk);
    hresetn = 1'b1;
    @(posedge clk); #1;
    drive_idle_bus();
  endtask

  initial begin
    hresetn = 1'b0;
    drive_idle_bus();
    hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    check_idle_out("reset");
    @(negedge clk);
    hresetn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write.
    xfer(2'b10, 1'b1, 32'h0300_0010, 32'hA5A5_5A5A, 32'h0, 0, 1'b0);
    // Read with two wait states.
    xfer(2'b10, 1'b0, 32'h0300_0014, 32'hDEAD_BEEF, 32'h1234_5678, 2, 1'b0);
    filter_beat(2);
    // Slave error.
    xfer(2'b10, 1'b1, 32'h0300_0020, 32'h0BAD_F00D, 32'h0, 0, 1'b1);
    // Watchdog abort on a read; HRDATA must not change.
    xfer(2'b10, 1'b0, 32'h0300_0024, 32'h0, 32'hFFFF_0000, 20, 1'b0);
    // PREADY arrives on the cycle the count would hit Timeout.
    xfer(2'b10, 1'b0, 32'h0300_0028, 32'h0, 32'h5555_AAAA, int'(Timeout) - 1, 1'b0);
    // Back-to-back NONSEQ write then SEQ read.
    xfer(2'b10, 1'b1, 32'h0400_0000, 32'h0102_0304, 32'h0, 0, 1'b0);
    xfer(2'b11, 1'b0, 32'h0400_0004, 32'h0, 32'hCAFE_0001, 1, 1'b0);
    filter_beat(0);
    filter_beat(1);
    filter_beat(3);
    reset_mid_access(32'h0500_0000);
    xfer(2'b10, 1'b0, 32'h0500_0004, 32'h0, 32'h7777_8888, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
      xfer($urandom_range(0, 1) ? 2'b11 : 2'b10, 1'($urandom), $urandom, $urandom, $urandom,
           w, ($urandom_range(0, 5) == 0));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        filter_beat(int'($urandom_range(0, 3)));
      end
    end
    filter_beat(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
